// File: rtl/ahb_lite_dual_slave_mem_pkg.sv
// Shared AHB-Lite dual-slave memory definitions: bus widths, transfer encodings, lane helpers.
// Combinational helpers only; no latency, no flow control.
package ahb_lite_defs;

   localparam int DATAWIDTH    = 32;
   localparam int ADDRWIDTH    = 32;
   localparam int MEM_WORDS    = 1024;
   localparam int CLOCK_PERIOD = 10;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'd0,
      HSIZE_HALF = 3'd1,
      HSIZE_WORD = 3'd2
   } hsize_e;

   typedef enum logic {
      HRESP_OKAY  = 1'b0,
      HRESP_ERROR = 1'b1
   } hresp_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_ERR2
   } ctrl_state_e;

   // Little-endian byte lanes touched by a transfer of the given size and offset.
   function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] off);
      case (size)
         HSIZE_BYTE: lane_mask = 4'b0001 << off;
         HSIZE_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
         default:    lane_mask = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
      lane_merge = old_w;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) lane_merge[8*b +: 8] = new_w[8*b +: 8];
      end
   endfunction

endpackage

// File: rtl/ahb_lite_dual_slave_mem_ctrl.sv
// Per-port AHB-Lite slave controller: error checks, IDLE/DATA/ERR2 FSM, byte-lane write enables.
// Zero-wait OKAY data phase; errors stall one cycle (HREADYOUT=0) then complete with ERROR.
module ahb_lite_mem_ctrl
   import ahb_lite_defs::*;
#(
   parameter int ADDRWIDTH = ahb_lite_defs::ADDRWIDTH,
   parameter int MEM_WORDS = ahb_lite_defs::MEM_WORDS,
   localparam int IDXW     = $clog2(MEM_WORDS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 hsel,
   input  logic [ADDRWIDTH-1:0] haddr,
   input  logic [1:0]           htrans,
   input  logic                 hwrite,
   input  logic [2:0]           hsize,
   input  logic                 hready,
   output logic                 hreadyout,
   output logic                 hresp,
   output logic                 dev_selected,
   output logic                 error_bounds,
   output logic                 error_size,
   output logic                 error_offset,
   output logic                 error_no_idle,
   output logic                 rd_issue,
   output logic [3:0]           mem_write_enable,
   output logic [IDXW-1:0]      wr_idx
);

   localparam logic [ADDRWIDTH-1:0] MEM_BYTES = ADDRWIDTH'(4 * MEM_WORDS);

   ctrl_state_e     state_q, state_d;
   logic            err_first_q, err_first_d;
   logic            prev_acc_q, prev_acc_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [1:0]      off_q, off_d;
   logic [2:0]      size_q, size_d;
   logic            write_q, write_d;
   logic            err_any;

   assign dev_selected  = hsel & hready & htrans[1];
   assign error_bounds  = dev_selected & (haddr >= MEM_BYTES);
   assign error_size    = dev_selected & (hsize > 3'(HSIZE_WORD));
   assign error_offset  = dev_selected & (((hsize == HSIZE_HALF) & haddr[0]) |
                                          ((hsize == HSIZE_WORD) & (haddr[1:0] != 2'b00)));
   assign error_no_idle = dev_selected & (htrans == HTRANS_SEQ) & ~prev_acc_q;
   assign err_any       = error_bounds | error_size | error_offset | error_no_idle;
   assign rd_issue      = dev_selected & ~err_any & ~hwrite;

   // Reset gates the enable so a data phase cut short by reset never commits.
   assign mem_write_enable = (state_q == ST_DATA && write_q && !rst) ? lane_mask(size_q, off_q) : 4'b0000;
   assign wr_idx           = idx_q;

   always_comb begin
      state_d     = state_q;
      err_first_d = 1'b0;
      prev_acc_d  = prev_acc_q;
      idx_d       = idx_q;
      off_d       = off_q;
      size_d      = size_q;
      write_d     = write_q;
      hreadyout   = 1'b1;
      hresp       = HRESP_OKAY;
      if (state_q == ST_ERR2 && err_first_q) begin
         hreadyout = 1'b0;
         hresp     = HRESP_ERROR;
      end else begin
         if (state_q == ST_ERR2) hresp = HRESP_ERROR;
         if (hready) begin
            prev_acc_d = dev_selected;
            if (dev_selected && err_any) begin
               state_d     = ST_ERR2;
               err_first_d = 1'b1;
            end else if (dev_selected) begin
               state_d = ST_DATA;
               idx_d   = haddr[IDXW+1:2];
               off_d   = haddr[1:0];
               size_d  = hsize;
               write_d = hwrite;
            end else begin
               state_d = ST_IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         err_first_q <= 1'b0;
         prev_acc_q  <= 1'b0;
         idx_q       <= '0;
         off_q       <= 2'b00;
         size_q      <= 3'b000;
         write_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         err_first_q <= err_first_d;
         prev_acc_q  <= prev_acc_d;
         idx_q       <= idx_d;
         off_q       <= off_d;
         size_q      <= size_d;
         write_q     <= write_d;
      end
   end

endmodule

// File: rtl/ahb_lite_dual_slave_mem.sv
// Two AHB-Lite slave ports sharing one byte-lane dual-port RAM (read-first, port 0 wins write clashes).
// Reads issued in the address phase, data next cycle; OKAY never stalls, ERROR stalls one cycle.
module ahb_lite_dual_slave_mem
   import ahb_lite_defs::*;
#(
   parameter int DATAWIDTH = ahb_lite_defs::DATAWIDTH,
   parameter int ADDRWIDTH = ahb_lite_defs::ADDRWIDTH,
   parameter int MEM_WORDS = ahb_lite_defs::MEM_WORDS
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic                 HSEL0,
   input  logic [ADDRWIDTH-1:0] HADDR0,
   input  logic [1:0]           HTRANS0,
   input  logic                 HWRITE0,
   input  logic [2:0]           HSIZE0,
   input  logic [2:0]           HBURST0,
   input  logic [3:0]           HPROT0,
   input  logic                 HREADY0,
   input  logic [DATAWIDTH-1:0] HWDATA0,
   output logic [DATAWIDTH-1:0] HRDATA0,
   output logic                 HREADYOUT0,
   output logic                 HRESP0,
   input  logic                 HSEL1,
   input  logic [ADDRWIDTH-1:0] HADDR1,
   input  logic [1:0]           HTRANS1,
   input  logic                 HWRITE1,
   input  logic [2:0]           HSIZE1,
   input  logic [2:0]           HBURST1,
   input  logic [3:0]           HPROT1,
   input  logic                 HREADY1,
   input  logic [DATAWIDTH-1:0] HWDATA1,
   output logic [DATAWIDTH-1:0] HRDATA1,
   output logic                 HREADYOUT1,
   output logic                 HRESP1
);

   localparam int IDXW = $clog2(MEM_WORDS);

   logic [DATAWIDTH-1:0] mem [MEM_WORDS];
   logic [3:0]           we0, we1;
   logic [IDXW-1:0]      widx0, widx1, ridx0, ridx1;
   logic                 rd0, rd1;
   logic [DATAWIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic [4:0]           unused_flags0, unused_flags1;
   logic                 unused_ok;

   assign unused_ok = ^{HBURST0, HPROT0, HBURST1, HPROT1, unused_flags0, unused_flags1};
   assign ridx0     = HADDR0[IDXW+1:2];
   assign ridx1     = HADDR1[IDXW+1:2];

   ahb_lite_mem_ctrl #(.ADDRWIDTH(ADDRWIDTH), .MEM_WORDS(MEM_WORDS)) MC0 (
      .clk(HCLK), .rst(HRESETn), .hsel(HSEL0), .haddr(HADDR0), .htrans(HTRANS0),
      .hwrite(HWRITE0), .hsize(HSIZE0), .hready(HREADY0),
      .hreadyout(HREADYOUT0), .hresp(HRESP0), .dev_selected(unused_flags0[0]),
      .error_bounds(unused_flags0[1]), .error_size(unused_flags0[2]),
      .error_offset(unused_flags0[3]), .error_no_idle(unused_flags0[4]),
      .rd_issue(rd0), .mem_write_enable(we0), .wr_idx(widx0)
   );

   ahb_lite_mem_ctrl #(.ADDRWIDTH(ADDRWIDTH), .MEM_WORDS(MEM_WORDS)) MC1 (
      .clk(HCLK), .rst(HRESETn), .hsel(HSEL1), .haddr(HADDR1), .htrans(HTRANS1),
      .hwrite(HWRITE1), .hsize(HSIZE1), .hready(HREADY1),
      .hreadyout(HREADYOUT1), .hresp(HRESP1), .dev_selected(unused_flags1[0]),
      .error_bounds(unused_flags1[1]), .error_size(unused_flags1[2]),
      .error_offset(unused_flags1[3]), .error_no_idle(unused_flags1[4]),
      .rd_issue(rd1), .mem_write_enable(we1), .wr_idx(widx1)
   );

   // Same-port bypass merges the in-flight write; the other port's write is not seen (read-first).
   always_comb begin
      rdata0_d = '0;
      rdata1_d = '0;
      if (rd0) begin
         rdata0_d = mem[ridx0];
         if (widx0 == ridx0) rdata0_d = lane_merge(rdata0_d, HWDATA0, we0);
      end
      if (rd1) begin
         rdata1_d = mem[ridx1];
         if (widx1 == ridx1) rdata1_d = lane_merge(rdata1_d, HWDATA1, we1);
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESETn) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   // Port 0 is written last so it owns any byte both ports hit in the same cycle.
   always_ff @(posedge HCLK) begin
      for (int b = 0; b < 4; b++) begin
         if (we1[b]) mem[widx1][8*b +: 8] <= HWDATA1[8*b +: 8];
         if (we0[b]) mem[widx0][8*b +: 8] <= HWDATA0[8*b +: 8];
      end
   end

   assign HRDATA0 = rdata0_q;
   assign HRDATA1 = rdata1_q;

endmodule

// File: tb/tb_ahb_lite_dual_slave_mem.sv
// Directed bench for the dual-port AHB-Lite memory; HREADY of each port loops back from HREADYOUT.
module tb_ahb_lite_dual_slave_mem;
   import ahb_lite_defs::*;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        hsel0, hwrite0, hready0, hreadyout0, hresp0;
   logic        hsel1, hwrite1, hready1, hreadyout1, hresp1;
   logic [31:0] haddr0, hwdata0, hrdata0, haddr1, hwdata1, hrdata1;
   logic [1:0]  htrans0, htrans1;
   logic [2:0]  hsize0, hsize1;
   logic [2:0]  hburst0 = 3'd0, hburst1 = 3'd0;
   logic [3:0]  hprot0 = 4'd0, hprot1 = 4'd0;
   int          checks = 0;
   int          errors = 0;

   localparam logic [1:0] NS = 2'd2, SQ = 2'd3;
   localparam logic [2:0] BY = 3'd0, WD = 3'd2;

   always #(CLOCK_PERIOD / 2) hclk = ~hclk;

   assign hready0 = hreadyout0;
   assign hready1 = hreadyout1;

   ahb_lite_dual_slave_mem dut (
      .HCLK(hclk), .HRESETn(hresetn),
      .HSEL0(hsel0), .HADDR0(haddr0), .HTRANS0(htrans0), .HWRITE0(hwrite0), .HSIZE0(hsize0),
      .HBURST0(hburst0), .HPROT0(hprot0), .HREADY0(hready0), .HWDATA0(hwdata0),
      .HRDATA0(hrdata0), .HREADYOUT0(hreadyout0), .HRESP0(hresp0),
      .HSEL1(hsel1), .HADDR1(haddr1), .HTRANS1(htrans1), .HWRITE1(hwrite1), .HSIZE1(hsize1),
      .HBURST1(hburst1), .HPROT1(hprot1), .HREADY1(hready1), .HWDATA1(hwdata1),
      .HRDATA1(hrdata1), .HREADYOUT1(hreadyout1), .HRESP1(hresp1)
   );

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic p0(input logic [1:0] tr, input logic wr, input logic [2:0] sz, input logic [31:0] a);
      hsel0 = 1'b1; htrans0 = tr; hwrite0 = wr; hsize0 = sz; haddr0 = a;
   endtask

   task automatic p1(input logic [1:0] tr, input logic wr, input logic [2:0] sz, input logic [31:0] a);
      hsel1 = 1'b1; htrans1 = tr; hwrite1 = wr; hsize1 = sz; haddr1 = a;
   endtask

   task automatic idle0();
      hsel0 = 1'b0; htrans0 = 2'd0; hwrite0 = 1'b0;
   endtask

   task automatic idle1();
      hsel1 = 1'b0; htrans1 = 2'd0; hwrite1 = 1'b0;
   endtask

   initial begin
      hresetn = 1'b1;
      idle0(); idle1();
      haddr0 = '0; haddr1 = '0; hsize0 = WD; hsize1 = WD; hwdata0 = '0; hwdata1 = '0;
      step(); step();
      chk("rst_rdy0", {31'd0, hreadyout0}, 32'd1);
      chk("rst_resp0", {31'd0, hresp0}, 32'd0);
      chk("rst_rdata0", hrdata0, 32'd0);
      chk("rst_rdy1", {31'd0, hreadyout1}, 32'd1);
      chk("rst_resp1", {31'd0, hresp1}, 32'd0);
      chk("rst_rdata1", hrdata1, 32'd0);
      hresetn = 1'b0;

      // Preload word 0x000 (port 1) and 0x030 (port 0)
      p1(NS, 1'b1, WD, 32'h000); p0(NS, 1'b1, WD, 32'h030); step();
      hwdata1 = 32'hCAFEF00D; hwdata0 = 32'h12345678; idle0(); idle1(); step();

      // Port 0 write, port 1 read back
      p0(NS, 1'b1, WD, 32'h010); step();
      hwdata0 = 32'hDEADBEEF; idle0();
      chk("wr_dphase_rdy0", {31'd0, hreadyout0}, 32'd1);
      chk("wr_dphase_resp0", {31'd0, hresp0}, 32'd0);
      step();
      p1(NS, 1'b0, WD, 32'h010); step();
      idle1();
      chk("xport_rdata1", hrdata1, 32'hDEADBEEF);
      chk("xport_rdy1", {31'd0, hreadyout1}, 32'd1);
      chk("xport_resp1", {31'd0, hresp1}, 32'd0);
      step();

      // Byte write into lane 3, read back through the same-port bypass
      p0(NS, 1'b1, WD, 32'h010); step();
      hwdata0 = 32'h11223344; p0(NS, 1'b1, BY, 32'h013); step();
      hwdata0 = 32'hAB000000; p0(NS, 1'b0, WD, 32'h010); step();
      idle0(); p1(NS, 1'b0, WD, 32'h010);
      chk("bypass_rdata0", hrdata0, 32'hAB223344);
      chk("bypass_rdy0", {31'd0, hreadyout0}, 32'd1);
      step();
      idle1();
      chk("byte_ram_rdata1", hrdata1, 32'hAB223344);
      step();

      // Out-of-range read: two-cycle ERROR, then a clean read
      p1(NS, 1'b0, WD, 32'h1000); step();
      idle1();
      chk("bounds_e1_rdy1", {31'd0, hreadyout1}, 32'd0);
      chk("bounds_e1_resp1", {31'd0, hresp1}, 32'd1);
      chk("bounds_e1_rdata1", hrdata1, 32'd0);
      step();
      chk("bounds_e2_rdy1", {31'd0, hreadyout1}, 32'd1);
      chk("bounds_e2_resp1", {31'd0, hresp1}, 32'd1);
      chk("bounds_e2_rdata1", hrdata1, 32'd0);
      p1(NS, 1'b0, WD, 32'h000); step();
      idle1();
      chk("after_err_rdata1", hrdata1, 32'hCAFEF00D);
      chk("after_err_resp1", {31'd0, hresp1}, 32'd0);
      chk("after_err_rdy1", {31'd0, hreadyout1}, 32'd1);
      step();

      // SEQ after an IDLE phase is an error; SEQ after NONSEQ is fine
      p1(SQ, 1'b0, WD, 32'h000); step();
      idle1();
      chk("seq_e1_rdy1", {31'd0, hreadyout1}, 32'd0);
      chk("seq_e1_resp1", {31'd0, hresp1}, 32'd1);
      step();
      chk("seq_e2_resp1", {31'd0, hresp1}, 32'd1);
      p1(NS, 1'b0, WD, 32'h000); step();
      p1(SQ, 1'b0, WD, 32'h010);
      chk("burst_nseq_rdata1", hrdata1, 32'hCAFEF00D);
      step();
      idle1();
      chk("burst_seq_rdata1", hrdata1, 32'hAB223344);
      chk("burst_seq_resp1", {31'd0, hresp1}, 32'd0);
      step();

      // Misaligned word write and HSIZE=3 write: both ERROR, RAM untouched
      p0(NS, 1'b1, WD, 32'h002); step();
      hwdata0 = 32'h55555555; idle0();
      chk("offset_e1_rdy0", {31'd0, hreadyout0}, 32'd0);
      chk("offset_e1_resp0", {31'd0, hresp0}, 32'd1);
      step();
      chk("offset_e2_resp0", {31'd0, hresp0}, 32'd1);
      p0(NS, 1'b1, 3'd3, 32'h000); step();
      hwdata0 = 32'hFFFFFFFF; idle0();
      chk("size_e1_rdy0", {31'd0, hreadyout0}, 32'd0);
      chk("size_e1_resp0", {31'd0, hresp0}, 32'd1);
      step();
      chk("size_e2_rdy0", {31'd0, hreadyout0}, 32'd1);
      chk("size_e2_resp0", {31'd0, hresp0}, 32'd1);
      p0(NS, 1'b0, WD, 32'h000); step();
      idle0();
      chk("err_nowrite_rdata0", hrdata0, 32'hCAFEF00D);
      chk("err_nowrite_resp0", {31'd0, hresp0}, 32'd0);
      step();

      // Read-first when the other port writes the same word
      p0(NS, 1'b1, WD, 32'h030); step();
      hwdata0 = 32'h9ABCDEF0; idle0(); p1(NS, 1'b0, WD, 32'h030); step();
      idle1();
      chk("read_first_rdata1", hrdata1, 32'h12345678);
      step();

      // Simultaneous writes to one word: port 0 wins
      p0(NS, 1'b1, WD, 32'h020); p1(NS, 1'b1, WD, 32'h020); step();
      hwdata0 = 32'h00000001; hwdata1 = 32'h00000002; idle0(); idle1(); step();
      p1(NS, 1'b0, WD, 32'h020); p0(NS, 1'b0, WD, 32'h030); step();
      idle0(); idle1();
      chk("clash_rdata1", hrdata1, 32'h00000001);
      chk("new_word_rdata0", hrdata0, 32'h9ABCDEF0);
      step();

      // Reset during a write data phase aborts the write
      p0(NS, 1'b1, WD, 32'h010); step();
      hwdata0 = 32'h00000000; idle0(); hresetn = 1'b1; p1(NS, 1'b0, WD, 32'h010); step();
      hresetn = 1'b0; idle1();
      chk("midrst_rdy0", {31'd0, hreadyout0}, 32'd1);
      chk("midrst_resp0", {31'd0, hresp0}, 32'd0);
      chk("midrst_rdata0", hrdata0, 32'd0);
      chk("midrst_rdata1", hrdata1, 32'd0);
      chk("midrst_rdy1", {31'd0, hreadyout1}, 32'd1);
      p1(NS, 1'b0, WD, 32'h010); step();
      idle1();
      chk("midrst_word_kept", hrdata1, 32'hAB223344);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_lite_dual_slave_mem.md
AHB_LITE_DUAL_SLAVE_MEM -- requirements
Module: ahb_lite_dual_slave_mem

Interface
REQ-001 Parameter DATAWIDTH, default 32, data bus width in bits; fixed to 32 in this revision.
REQ-002 Parameter ADDRWIDTH, default 32, width of HADDR on each port.
REQ-003 Parameter MEM_WORDS, default 1024, number of 32-bit RAM words, giving a 4 KB byte space.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 HCLK  in  1  system clock; all state changes on its rising edge.
REQ-006 HRESETn  in  1  synchronous, active-high reset; the codebase port name is kept.
REQ-007 Per port p in {0,1}: HSELp  in  1  slave select.
REQ-008 HADDRp  in  ADDRWIDTH  byte address.
REQ-009 HTRANSp  in  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-010 HWRITEp  in  1  1 = write.
REQ-011 HSIZEp  in  3  transfer size: 0=byte, 1=half, 2=word.
REQ-012 HBURSTp and HPROTp  in  3/4  accepted and ignored.
REQ-013 HREADYp  in  1  bus-level ready.
REQ-014 HWDATAp  in  DATAWIDTH  write data, valid in the data phase.
REQ-015 HRDATAp  out  DATAWIDTH  read data.
REQ-016 HREADYOUTp  out  1  slave ready.
REQ-017 HRESPp  out  1  0 = OKAY, 1 = ERROR.

Function
REQ-018 Both ports share one dual-port RAM of MEM_WORDS words; word index = HADDR[11:2]; byte lanes are little-endian.
REQ-019 An address phase is accepted when HSELp=1, HREADYp=1 and HTRANSp is NONSEQ or SEQ; its controls are registered for the data phase on the next cycle.
REQ-020 Each accepted transfer is checked for four errors:
- bounds: HADDR >= 4*MEM_WORDS.
- size: HSIZE > 2.
- offset: misalignment, i.e. half with HADDR[0]=1, or word with HADDR[1:0]!=0.
- sequence: SEQ with no NONSEQ/SEQ accepted in the previous address phase.
REQ-021 For an error-free transfer the data phase completes in zero wait states with HREADYOUT=1 and HRESP=0.
REQ-022 Write data phase: update only the byte lanes selected by the registered HSIZE and HADDR[1:0], using HWDATA.
REQ-023 Read: the RAM read is issued in the address phase; HRDATA is valid in the data phase as the full 32-bit word, without lane masking.
REQ-024 Same-port write immediately followed by a read of the same word: HRDATA returns the merged new data through a bypass, with no wait state.
REQ-025 Error response takes two cycles:
- cycle 1: HREADYOUT=0, HRESP=1.
- cycle 2: HREADYOUT=1, HRESP=1.
- No RAM write occurs, and HRDATA=0.
REQ-026 IDLE or BUSY transfers, or HSEL=0, give a zero-wait OKAY response with no RAM access.
REQ-027 Both ports writing the same word in the same cycle: per-byte, port 0 wins.
REQ-028 A port reading a word the other port writes in the same cycle returns the old contents (read-first).
REQ-029 Per-port controller states are IDLE, DATA and ERR2.
- Error-free accept goes to DATA; errored accept goes to ERR2 through the first error cycle.
- ERR2 returns to IDLE or DATA according to the next accepted phase.

Reset
REQ-030 While HRESETn=1 at a clock edge:
- HREADYOUT=1, HRESP=0, HRDATA=0.
- Controller state is IDLE; registered address-phase and sequence history are cleared.
REQ-031 Reset asserted mid-transfer aborts any pending write.
REQ-032 RAM contents are not cleared by reset.

Structure
REQ-033 A shared package ahb_lite_defs holds:
- DATAWIDTH, ADDRWIDTH and MEM_WORDS.
- CLOCK_PERIOD.
- The HTRANS, HSIZE and HRESP enums.
REQ-034 One sub-module, ahb_lite_mem_ctrl, is instantiated twice (MC0, MC1). It contains the error checks, the state machine and the lane-write-enable generation, and exposes error_bounds, error_size, error_no_idle, error_offset, dev_selected and mem_write_enable.
REQ-035 The RAM is inferred in the top module.

Verification
REQ-036 Port 0 word write 0xDEADBEEF to 0x010, then port 1 word read of 0x010 -> HRDATA1=0xDEADBEEF, OKAY, zero wait.
REQ-037 Port 0 byte write 0xAB to 0x013 over word 0x11223344, then read -> 0xAB223344.
REQ-038 Port 1 NONSEQ read of 0x1000 -> two-cycle ERROR (HREADYOUT 0 then 1, HRESP 1,1); the next NONSEQ read of 0x000 returns OKAY.
REQ-039 Word access to 0x002 and HSIZE=3 access to 0x000 -> ERROR each; the RAM is unchanged.
REQ-040 Both ports write 0x20 in the same cycle (0x1 from port 0, 0x2 from port 1) -> a later read returns 0x00000001.
REQ-041 Reset asserted during a write data phase -> the word is unchanged, and outputs read HREADYOUT=1, HRESP=0, HRDATA=0.
